// File: rtl/riscv_pipeline_top.sv
// RV32I integer core: five-stage IF/ID/EX/MEM/WB pipeline with combinational fetch,
// EX-stage operand forwarding and a write-before-read register file. No loads, stores or branches.

module RegisterFile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] RegFiles [0:31] = '{default: 32'h0};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) RegFiles[i] <= 32'h0;
    end else if (we && (wa != 5'd0)) begin
      RegFiles[wa] <= wd;
    end
  end

  // A write landing this cycle is bypassed so ID sees the value WB is committing.
  always_comb begin
    rdata1 = RegFiles[rs1];
    rdata2 = RegFiles[rs2];
    if (we && (wa != 5'd0) && (wa == rs1)) rdata1 = wd;
    if (we && (wa != 5'd0) && (wa == rs2)) rdata2 = wd;
    if (rs1 == 5'd0) rdata1 = 32'h0;
    if (rs2 == 5'd0) rdata2 = 32'h0;
  end

endmodule

module riscv_core (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] InstAddr,
  input  logic [31:0] Instruction
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {A_REG, A_PC, A_ZERO} asel_t;

  logic [31:0] pc = 32'h0;
  logic [31:0] ifid_inst = 32'h0;
  logic [31:0] ifid_pc = 32'h0;

  logic [31:0] idex_pc = 32'h0;
  logic [31:0] idex_rv1 = 32'h0;
  logic [31:0] idex_rv2 = 32'h0;
  logic [31:0] idex_imm = 32'h0;
  logic [4:0]  idex_rs1 = 5'd0;
  logic [4:0]  idex_rs2 = 5'd0;
  logic [4:0]  idex_rd = 5'd0;
  logic        idex_we = 1'b0;
  logic        idex_bimm = 1'b0;
  alu_op_t     idex_op = ALU_ADD;
  asel_t       idex_asel = A_REG;

  logic [31:0] exmem_result = 32'h0;
  logic [4:0]  exmem_rd = 5'd0;
  logic        exmem_we = 1'b0;

  logic [31:0] memwb_result = 32'h0;
  logic [4:0]  memwb_rd = 5'd0;
  logic        memwb_we = 1'b0;

  logic [6:0]  id_opcode;
  logic [2:0]  id_f3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm, id_rv1, id_rv2;
  logic        id_we, id_bimm;
  alu_op_t     id_op;
  asel_t       id_asel;

  logic [31:0] fwd_a, fwd_b, alu_a, alu_b, alu_result;
  logic [4:0]  shamt;

  assign InstAddr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= 32'h0;
      ifid_inst <= 32'h0;
      ifid_pc   <= 32'h0;
    end else begin
      pc        <= pc + 32'd4;
      ifid_inst <= Instruction;
      ifid_pc   <= pc;
    end
  end

  assign id_opcode = ifid_inst[6:0];
  assign id_f3     = ifid_inst[14:12];
  assign id_rs1    = ifid_inst[19:15];
  assign id_rs2    = ifid_inst[24:20];
  assign id_rd     = ifid_inst[11:7];

  RegisterFile u_RegisterFile (
    .clk    (clk),
    .reset  (reset),
    .rs1    (id_rs1),
    .rs2    (id_rs2),
    .rdata1 (id_rv1),
    .rdata2 (id_rv2),
    .we     (memwb_we),
    .wa     (memwb_rd),
    .wd     (memwb_result)
  );

  // Unsupported opcodes fall through with id_we=0 and behave as NOPs.
  always_comb begin
    id_we   = 1'b0;
    id_bimm = 1'b1;
    id_asel = A_REG;
    id_imm  = {{20{ifid_inst[31]}}, ifid_inst[31:20]};
    case (id_f3)
      3'b000:  id_op = (id_opcode == 7'b0110011 && ifid_inst[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  id_op = ALU_SLL;
      3'b010:  id_op = ALU_SLT;
      3'b011:  id_op = ALU_SLTU;
      3'b100:  id_op = ALU_XOR;
      3'b101:  id_op = ifid_inst[30] ? ALU_SRA : ALU_SRL;
      3'b110:  id_op = ALU_OR;
      default: id_op = ALU_AND;
    endcase
    case (id_opcode)
      7'b0110111: begin
        id_we   = 1'b1;
        id_asel = A_ZERO;
        id_imm  = {ifid_inst[31:12], 12'h000};
        id_op   = ALU_ADD;
      end
      7'b0010111: begin
        id_we   = 1'b1;
        id_asel = A_PC;
        id_imm  = {ifid_inst[31:12], 12'h000};
        id_op   = ALU_ADD;
      end
      7'b0010011: id_we = 1'b1;
      7'b0110011: begin
        id_we   = 1'b1;
        id_bimm = 1'b0;
      end
      default: id_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_we <= 1'b0;
      idex_rd <= 5'd0;
    end else begin
      idex_we <= id_we;
      idex_rd <= id_rd;
    end
    idex_pc   <= ifid_pc;
    idex_rv1  <= id_rv1;
    idex_rv2  <= id_rv2;
    idex_imm  <= id_imm;
    idex_rs1  <= id_rs1;
    idex_rs2  <= id_rs2;
    idex_op   <= id_op;
    idex_asel <= id_asel;
    idex_bimm <= id_bimm;
  end

  // The younger producer (EX/MEM) wins over MEM/WB when both target the same source.
  always_comb begin
    fwd_a = idex_rv1;
    fwd_b = idex_rv2;
    if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == idex_rs1)) fwd_a = memwb_result;
    if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == idex_rs2)) fwd_b = memwb_result;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == idex_rs1)) fwd_a = exmem_result;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == idex_rs2)) fwd_b = exmem_result;
  end

  always_comb begin
    case (idex_asel)
      A_PC:    alu_a = idex_pc;
      A_ZERO:  alu_a = 32'h0;
      default: alu_a = fwd_a;
    endcase
    alu_b = idex_bimm ? idex_imm : fwd_b;
    shamt = alu_b[4:0];
    case (idex_op)
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SLT:  alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'h0, alu_a < alu_b};
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      default:  alu_result = alu_a + alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_we <= 1'b0;
      exmem_rd <= 5'd0;
      memwb_we <= 1'b0;
      memwb_rd <= 5'd0;
    end else begin
      exmem_we <= idex_we;
      exmem_rd <= idex_rd;
      memwb_we <= exmem_we;
      memwb_rd <= exmem_rd;
    end
    exmem_result <= alu_result;
    memwb_result <= exmem_result;
  end

endmodule

module riscv_pipeline_top (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] InstAddr,
  input  logic [31:0] Instruction
);

  riscv_core core (
    .clk         (clk),
    .reset       (reset),
    .InstAddr    (InstAddr),
    .Instruction (Instruction)
  );

endmodule

// File: tb/tb_riscv_pipeline_top.sv
// Directed bench for riscv_pipeline_top: drives one instruction per edge and checks
// register-file results through a scoreboard of expected writebacks.

module tb_riscv_pipeline_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] InstAddr;
  logic [31:0] Instruction = 32'h0;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  int          checkCount = 0;
  int          passCount = 0;
  int          edgeCount = 0;
  logic [31:0] expPc = 32'h0;

  riscv_pipeline_top dut (
    .clk         (clk),
    .reset       (reset),
    .InstAddr    (InstAddr),
    .Instruction (Instruction)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] encR(input logic alt, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAllRegs(input string tag, input int firstReg);
    for (int i = firstReg; i < 32; i++)
      checkOutput($sformatf("%s_x%0d", tag, i), dut.core.u_RegisterFile.RegFiles[i], 32'h0);
  endtask

  // One fetch edge: check the PC, present the word, then retire whatever is due.
  task automatic applyStimulus(input logic [31:0] inst, input bit expectWrite,
                               input logic [4:0] rd, input logic [31:0] val);
    exp_t e;
    checkOutput($sformatf("pc@%0d", edgeCount), InstAddr, expPc);
    Instruction = inst;
    if (expectWrite) begin
      e.due = edgeCount + 5;
      e.rd  = rd;
      e.val = val;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    edgeCount++;
    expPc = expPc + 32'd4;
    while (sbq.size() > 0 && sbq[0].due == edgeCount) begin
      e = sbq.pop_front();
      checkOutput($sformatf("x%0d", e.rd), dut.core.u_RegisterFile.RegFiles[e.rd], e.val);
    end
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at edge %0d", edgeCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1;
    checkAllRegs("poweron", 0);

    // Idle fetch with no reset ever applied; PC walks 0,4,8,C.
    nop(4);
    applyStimulus(encU(20'h0000f, 5'd8, 7'b0010111), 1'b1, 5'd8, 32'h0000f010);
    applyStimulus(encU(20'hfffff, 5'd2, 7'b0110111), 1'b1, 5'd2, 32'hfffff000);
    applyStimulus(encU(20'hffffe, 5'd1, 7'b0110111), 1'b1, 5'd1, 32'hffffe000);
    applyStimulus(32'h00110233, 1'b1, 5'd4, 32'hffffd000);
    applyStimulus(encI(12'd2, 5'd2, 3'b000, 5'd2), 1'b1, 5'd2, 32'hfffff002);
    applyStimulus(encI(12'd4, 5'd2, 3'b001, 5'd3), 1'b1, 5'd3, 32'hffff0020);
    applyStimulus(encI(12'h408, 5'd3, 3'b101, 5'd5), 1'b1, 5'd5, 32'hffffff00);
    applyStimulus(encI(12'h008, 5'd3, 3'b101, 5'd6), 1'b1, 5'd6, 32'h00ffff00);
    applyStimulus(encI(12'd5, 5'd0, 3'b000, 5'd0), 1'b1, 5'd0, 32'h0);
    applyStimulus(encR(1'b0, 5'd0, 5'd0, 3'b000, 5'd7), 1'b1, 5'd7, 32'h0);
    applyStimulus(encR(1'b0, 5'd0, 5'd1, 3'b010, 5'd9), 1'b1, 5'd9, 32'h1);
    applyStimulus(encR(1'b0, 5'd0, 5'd1, 3'b011, 5'd10), 1'b1, 5'd10, 32'h0);
    applyStimulus(encR(1'b1, 5'd1, 5'd2, 3'b000, 5'd11), 1'b1, 5'd11, 32'h00001002);
    applyStimulus(encR(1'b0, 5'd1, 5'd2, 3'b100, 5'd12), 1'b1, 5'd12, 32'h00001002);
    applyStimulus(encR(1'b0, 5'd1, 5'd2, 3'b110, 5'd13), 1'b1, 5'd13, 32'hfffff002);
    applyStimulus(encR(1'b0, 5'd1, 5'd2, 3'b111, 5'd14), 1'b1, 5'd14, 32'hffffe000);
    applyStimulus(encI(12'hfff, 5'd1, 3'b011, 5'd15), 1'b1, 5'd15, 32'h1);
    applyStimulus(encI(12'hfff, 5'd1, 3'b010, 5'd16), 1'b1, 5'd16, 32'h1);
    applyStimulus(encI(12'hfff, 5'd1, 3'b100, 5'd17), 1'b1, 5'd17, 32'h00001fff);
    applyStimulus(encI(12'h7ff, 5'd0, 3'b110, 5'd18), 1'b1, 5'd18, 32'h000007ff);
    applyStimulus(encI(12'h0ff, 5'd2, 3'b111, 5'd19), 1'b1, 5'd19, 32'h00000002);
    applyStimulus(encR(1'b1, 5'd18, 5'd1, 3'b101, 5'd20), 1'b1, 5'd20, 32'hffffffff);
    applyStimulus(encR(1'b0, 5'd18, 5'd1, 3'b101, 5'd21), 1'b1, 5'd21, 32'h00000001);
    applyStimulus(encR(1'b0, 5'd19, 5'd18, 3'b001, 5'd22), 1'b1, 5'd22, 32'h00001ffc);
    applyStimulus(encR(1'b0, 5'd1, 5'd18, 3'b011, 5'd23), 1'b1, 5'd23, 32'h1);
    nop(5);
    checkOutput("sb_drained", 32'(sbq.size()), 32'h0);
    checkOutput("x0_final", dut.core.u_RegisterFile.RegFiles[0], 32'h0);

    // Four writes in flight, then a single reset edge must discard all of them.
    applyStimulus(encI(12'd1, 5'd0, 3'b000, 5'd24), 1'b0, 5'd0, 32'h0);
    applyStimulus(encI(12'd2, 5'd0, 3'b000, 5'd25), 1'b0, 5'd0, 32'h0);
    applyStimulus(encI(12'd3, 5'd0, 3'b000, 5'd26), 1'b0, 5'd0, 32'h0);
    applyStimulus(encI(12'd4, 5'd0, 3'b000, 5'd27), 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    Instruction = encI(12'd5, 5'd0, 3'b000, 5'd28);
    @(posedge clk);
    #1;
    edgeCount++;
    expPc = 32'h0;
    checkOutput("pc_after_reset", InstAddr, 32'h0);
    checkAllRegs("reset", 0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(encI(12'h123, 5'd0, 3'b000, 5'd1), 1'b1, 5'd1, 32'h00000123);
    applyStimulus(encU(20'h00001, 5'd2, 7'b0010111), 1'b1, 5'd2, 32'h00001004);
    nop(5);
    checkOutput("sb_drained_post", 32'(sbq.size()), 32'h0);
    checkAllRegs("post", 3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
